// File: rtl/lockstep_pkg.sv
// Shared constants for the lockstep barrier unit and the lockstep controller.
package lockstep_pkg;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h1020_2500;

  localparam int unsigned OFF_TARGET     = 0;
  localparam int unsigned OFF_ARRIVE     = 4;
  localparam int unsigned BARRIER_STRIDE = 8;

  localparam int unsigned MAX_CORES    = 8;
  localparam int unsigned MAX_BARRIERS = 8;

  typedef enum logic [1:0] {
    REG_NONE,
    REG_TARGET,
    REG_ARRIVE
  } reg_sel_e;

endpackage

// File: rtl/barrier_slice.sv
// One barrier: target mask, arrived mask and a registered match pulse.
module barrier_slice #(
  parameter int unsigned NB_CORES = 8
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                wr_target_i,
  input  logic                wr_arrive_i,
  input  logic [2:0]          core_idx_i,
  input  logic [NB_CORES-1:0] wdata_i,
  output logic [NB_CORES-1:0] target_o,
  output logic [NB_CORES-1:0] arrived_o,
  output logic                match_next_o,
  output logic                match_o
);

  logic [NB_CORES-1:0] target_q;
  logic [NB_CORES-1:0] arrived_q;
  logic [NB_CORES-1:0] arrive_bit;
  logic [NB_CORES-1:0] arrived_next;
  logic                match_q;

  always_comb begin
    arrive_bit = '0;
    if (wr_arrive_i) begin
      for (int unsigned c = 0; c < NB_CORES; c++) begin
        // Only cores that are part of the current target may arrive.
        if (core_idx_i == 3'(c)) arrive_bit[c] = target_q[c];
      end
    end
    arrived_next = wr_target_i ? '0 : (arrived_q | arrive_bit);
    match_next_o = (arrived_next == target_q) && (target_q != '0);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      target_q  <= '0;
      arrived_q <= '0;
      match_q   <= 1'b0;
    end else begin
      if (wr_target_i) target_q <= wdata_i;
      arrived_q <= match_next_o ? '0 : arrived_next;
      match_q   <= match_next_o;
    end
  end

  assign target_o  = target_q;
  assign arrived_o = arrived_q;
  assign match_o   = match_q;

endmodule

// File: rtl/lockstep_barrier_unit.sv
// Memory-mapped barrier unit: per-barrier TARGET/ARRIVE registers, match and wake-up pulses.
module lockstep_barrier_unit
  import lockstep_pkg::*;
#(
  parameter int unsigned NB_CORES    = 8,
  parameter int unsigned NB_BARRIERS = 8,
  parameter int unsigned ID_WIDTH    = 5,
  parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                req_i,
  input  logic [31:0]         addr_i,
  input  logic                wen_i,
  input  logic [31:0]         wdata_i,
  input  logic [3:0]          be_i,
  input  logic [ID_WIDTH-1:0] id_i,
  output logic                gnt_o,
  output logic                r_valid_o,
  output logic                r_opc_o,
  output logic [ID_WIDTH-1:0] r_id_o,
  output logic [31:0]         r_rdata_o,
  output logic [7:0]          barrier_matched_o,
  output logic [NB_CORES-1:0] event_o
);

  reg_sel_e            sel;
  logic [2:0]          bidx;
  logic [31:0]         rdata_d;
  logic [NB_CORES-1:0] event_d;

  logic [NB_BARRIERS-1:0] wr_target;
  logic [NB_BARRIERS-1:0] wr_arrive;
  logic [NB_BARRIERS-1:0] match_next;
  logic [NB_BARRIERS-1:0] match_q;
  logic [NB_CORES-1:0]    target  [NB_BARRIERS];
  logic [NB_CORES-1:0]    arrived [NB_BARRIERS];

  logic unused_inputs;
  assign unused_inputs = ^{be_i, wdata_i};

  assign gnt_o   = 1'b1;
  assign r_opc_o = 1'b0;

  always_comb begin
    sel  = REG_NONE;
    bidx = addr_i[5:3];
    if (req_i && (addr_i[31:6] == BASE_ADDR[31:6]) && (32'(bidx) < NB_BARRIERS)) begin
      if (addr_i[2:0] == 3'(OFF_TARGET))      sel = REG_TARGET;
      else if (addr_i[2:0] == 3'(OFF_ARRIVE)) sel = REG_ARRIVE;
    end
  end

  always_comb begin
    wr_target = '0;
    wr_arrive = '0;
    rdata_d   = '0;
    event_d   = '0;
    for (int unsigned b = 0; b < NB_BARRIERS; b++) begin
      if (bidx == 3'(b)) begin
        wr_target[b] = (sel == REG_TARGET) && !wen_i;
        wr_arrive[b] = (sel == REG_ARRIVE) && !wen_i;
        if (wen_i && sel == REG_TARGET) rdata_d[NB_CORES-1:0] = target[b];
        if (wen_i && sel == REG_ARRIVE) rdata_d[NB_CORES-1:0] = arrived[b];
      end
      if (match_next[b]) event_d = event_d | target[b];
    end
  end

  for (genvar g = 0; g < NB_BARRIERS; g++) begin : g_slice
    barrier_slice #(
      .NB_CORES(NB_CORES)
    ) u_slice (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .wr_target_i  (wr_target[g]),
      .wr_arrive_i  (wr_arrive[g]),
      .core_idx_i   (wdata_i[2:0]),
      .wdata_i      (wdata_i[NB_CORES-1:0]),
      .target_o     (target[g]),
      .arrived_o    (arrived[g]),
      .match_next_o (match_next[g]),
      .match_o      (match_q[g])
    );
  end

  always_comb begin
    barrier_matched_o = '0;
    barrier_matched_o[NB_BARRIERS-1:0] = match_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_valid_o <= 1'b0;
      r_id_o    <= '0;
      r_rdata_o <= '0;
      event_o   <= '0;
    end else begin
      r_valid_o <= req_i;
      if (req_i) r_id_o <= id_i;
      r_rdata_o <= rdata_d;
      event_o   <= event_d;
    end
  end

endmodule

// File: tb/tb_lockstep_barrier_unit.sv
// Vector table, reset corner case and randomized traffic against a set-based barrier model.
module tb_lockstep_barrier_unit;

  localparam logic [31:0] B = 32'h1020_2500;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        req_i = 1'b0;
  logic [31:0] addr_i = '0;
  logic        wen_i = 1'b1;
  logic [31:0] wdata_i = '0;
  logic [3:0]  be_i = '0;
  logic [4:0]  id_i = '0;
  logic        gnt_o, r_valid_o, r_opc_o;
  logic [4:0]  r_id_o;
  logic [31:0] r_rdata_o;
  logic [7:0]  barrier_matched_o;
  logic [7:0]  event_o;

  int tests = 0;
  int fails = 0;

  lockstep_barrier_unit #(
    .NB_CORES(8), .NB_BARRIERS(8), .ID_WIDTH(5), .BASE_ADDR(B)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .addr_i(addr_i), .wen_i(wen_i),
    .wdata_i(wdata_i), .be_i(be_i), .id_i(id_i), .gnt_o(gnt_o), .r_valid_o(r_valid_o),
    .r_opc_o(r_opc_o), .r_id_o(r_id_o), .r_rdata_o(r_rdata_o),
    .barrier_matched_o(barrier_matched_o), .event_o(event_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: per barrier a target set and an arrived set of cores.
  bit [7:0] m_tgt [8];
  bit       m_arr [8][8];

  task automatic model_reset();
    for (int b = 0; b < 8; b++) begin
      m_tgt[b] = '0;
      for (int c = 0; c < 8; c++) m_arr[b][c] = 1'b0;
    end
  endtask

  task automatic model_op(input bit wr, input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] rd, output logic [7:0] m, output logic [7:0] e);
    int b, c;
    bit done;
    rd = '0; m = '0; e = '0;
    if (a[31:6] == B[31:6] && (a[5:0] % 4) == 0) begin
      b = int'(a[5:0]) / 8;
      if ((a[5:0] % 8) == 0) begin
        if (!wr) rd = {24'b0, m_tgt[b]};
        else begin
          m_tgt[b] = d[7:0];
          for (c = 0; c < 8; c++) m_arr[b][c] = 1'b0;
        end
      end else if (!wr) begin
        for (c = 0; c < 8; c++) if (m_arr[b][c]) rd = rd + (32'd1 << c);
      end else begin
        c = int'(d[2:0]);
        if (m_tgt[b][c]) m_arr[b][c] = 1'b1;
        done = (m_tgt[b] != 0);
        for (c = 0; c < 8; c++) if (m_tgt[b][c] && !m_arr[b][c]) done = 1'b0;
        if (done) begin
          m[b] = 1'b1;
          e = m_tgt[b];
          for (c = 0; c < 8; c++) m_arr[b][c] = 1'b0;
        end
      end
    end
  endtask

  // One bus transaction driven at a negedge, response checked at the next negedge.
  task automatic bus_op(input string name, input bit wr, input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] exp_rd, input logic [7:0] exp_m, input logic [7:0] exp_e);
    logic [4:0] id;
    id = 5'($urandom_range(0, 31));
    req_i = 1'b1; wen_i = !wr; addr_i = a; wdata_i = d; be_i = 4'($urandom); id_i = id;
    #1 chk({name, ".gnt"}, {31'b0, gnt_o}, 32'd1);
    @(negedge clk_i);
    req_i = 1'b0;
    chk({name, ".valid"}, {31'b0, r_valid_o}, 32'd1);
    chk({name, ".id"}, {27'b0, r_id_o}, {27'b0, id});
    chk({name, ".opc"}, {31'b0, r_opc_o}, 32'd0);
    chk({name, ".rdata"}, r_rdata_o, exp_rd);
    chk({name, ".matched"}, {24'b0, barrier_matched_o}, {24'b0, exp_m});
    chk({name, ".event"}, {24'b0, event_o}, {24'b0, exp_e});
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] rd;
    logic [7:0]  m;
    logic [7:0]  e;
  } vec_t;

  vec_t vt[$];

  initial begin
    logic [31:0] erd;
    logic [7:0]  em, ee;
    logic [31:0] a;

    // Reset state
    repeat (2) @(negedge clk_i);
    chk("rst.valid", {31'b0, r_valid_o}, 32'd0);
    chk("rst.id", {27'b0, r_id_o}, 32'd0);
    chk("rst.rdata", r_rdata_o, 32'd0);
    chk("rst.matched", {24'b0, barrier_matched_o}, 32'd0);
    chk("rst.event", {24'b0, event_o}, 32'd0);
    rst_ni = 1'b1;
    @(negedge clk_i);

    vt.push_back('{0, B + 0,  0,    0, 8'h00, 8'h00});
    vt.push_back('{1, B + 0,  3,    0, 8'h00, 8'h00});
    vt.push_back('{1, B + 4,  0,    0, 8'h00, 8'h00});
    vt.push_back('{1, B + 4,  1,    0, 8'h01, 8'h03});
    vt.push_back('{0, B + 4,  0,    0, 8'h00, 8'h00});
    vt.push_back('{1, B + 16, 5,    0, 8'h00, 8'h00});
    vt.push_back('{1, B + 20, 1,    0, 8'h00, 8'h00});
    vt.push_back('{0, B + 20, 0,    0, 8'h00, 8'h00});
    vt.push_back('{1, B + 20, 0,    0, 8'h00, 8'h00});
    vt.push_back('{1, B + 20, 0,    0, 8'h00, 8'h00});
    vt.push_back('{0, B + 20, 0,    1, 8'h00, 8'h00});
    vt.push_back('{1, B + 20, 2,    0, 8'h04, 8'h05});
    vt.push_back('{1, B + 24, 15,   0, 8'h00, 8'h00});
    vt.push_back('{1, B + 28, 0,    0, 8'h00, 8'h00});
    vt.push_back('{1, B + 28, 1,    0, 8'h00, 8'h00});
    vt.push_back('{1, B + 28, 2,    0, 8'h00, 8'h00});
    vt.push_back('{0, B + 28, 0,    7, 8'h00, 8'h00});
    vt.push_back('{1, B + 24, 15,   0, 8'h00, 8'h00});
    vt.push_back('{0, B + 28, 0,    0, 8'h00, 8'h00});
    vt.push_back('{1, B + 28, 3,    0, 8'h00, 8'h00});
    vt.push_back('{0, B + 28, 0,    8, 8'h00, 8'h00});
    vt.push_back('{1, B + 8,  0,    0, 8'h00, 8'h00});
    vt.push_back('{1, B + 12, 0,    0, 8'h00, 8'h00});
    vt.push_back('{1, B + 256, 255, 0, 8'h00, 8'h00});
    vt.push_back('{0, B + 256, 0,   0, 8'h00, 8'h00});
    vt.push_back('{0, B + 0,  0,    3, 8'h00, 8'h00});
    vt.push_back('{1, B + 0,  1,    0, 8'h00, 8'h00});
    vt.push_back('{1, B + 4,  0,    0, 8'h01, 8'h01});
    vt.push_back('{1, B + 4,  0,    0, 8'h01, 8'h01});
    vt.push_back('{0, B + 0,  0,    1, 8'h00, 8'h00});

    for (int i = 0; i < vt.size(); i++)
      bus_op($sformatf("vec%0d", i), vt[i].wr, vt[i].addr, vt[i].data, vt[i].rd, vt[i].m, vt[i].e);

    // Reset mid-round discards 3 of 4 arrivals
    bus_op("mr.tgt", 1, B + 24, 15, 0, 0, 0);
    bus_op("mr.a0", 1, B + 28, 0, 0, 0, 0);
    bus_op("mr.a1", 1, B + 28, 1, 0, 0, 0);
    bus_op("mr.a2", 1, B + 28, 2, 0, 0, 0);
    rst_ni = 1'b0;
    #1;
    chk("mr.rst.valid", {31'b0, r_valid_o}, 32'd0);
    chk("mr.rst.matched", {24'b0, barrier_matched_o}, 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (2) begin
      @(negedge clk_i);
      chk("mr.idle.matched", {24'b0, barrier_matched_o}, 32'd0);
      chk("mr.idle.valid", {31'b0, r_valid_o}, 32'd0);
    end
    for (int b = 0; b < 4; b++) bus_op($sformatf("mr.tgt%0d", b), 0, B + 8 * b, 0, 0, 0, 0);
    bus_op("mr.a3", 1, B + 28, 3, 0, 0, 0);
    bus_op("mr.arr3", 0, B + 28, 0, 0, 0, 0);

    // Randomized traffic against the model
    model_reset();
    for (int i = 0; i < 400; i++) begin
      bit wr;
      logic [31:0] d;
      int r;
      r = $urandom_range(0, 19);
      a = B + 8 * $urandom_range(0, 7) + 4 * (($urandom_range(0, 2) != 0) ? 1 : 0);
      if (r == 0) a = B + 64 * $urandom_range(1, 4);
      else if (r == 1) a = a + 32'($urandom_range(1, 3));
      wr = ($urandom_range(0, 3) != 0);
      d = $urandom;
      if (a[2] == 1'b0) d[7:0] = ($urandom_range(0, 5) == 0) ? 8'($urandom) : 8'($urandom_range(0, 15));
      else d[2:0] = ($urandom_range(0, 4) == 0) ? 3'($urandom) : 3'($urandom_range(0, 3));
      model_op(wr, a, d, erd, em, ee);
      bus_op($sformatf("rnd%0d", i), wr, a, d, erd, em, ee);
    end

    @(negedge clk_i);
    chk("end.valid", {31'b0, r_valid_o}, 32'd0);
    chk("end.matched", {24'b0, barrier_matched_o}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
